// File: rtl/window_average_stream_if.sv
// Stream bundle between the window-average block and its producer/consumer.
// Latency: none, wires only.
// Backpressure: out_valid/out_ready handshake on the output side; the input side has no backpressure.
interface window_average_stream_if #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          in_en;
    logic [DW-1:0] in_sum;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          warm_done;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    // Producer/consumer side: drives samples and ready, observes the queue.
    modport master (
        output in_en, in_sum, out_ready,
        input  out_valid, out_data, warm_done, overflow, fifo_level
    );

    // Block side: receives samples and ready, presents the queue head and status.
    modport slave (
        input  in_en, in_sum, out_ready,
        output out_valid, out_data, warm_done, overflow, fifo_level
    );
endinterface

// File: rtl/window_average_stream.sv
// Purpose: drops warm-up window sums, rounds sum/2**N half-up, queues averages in a small FIFO (optional PEAK_TRACK_EN adds out_peak).
// Latency: 1 cycle from an accepted in_en edge to out_valid/out_data when the FIFO was empty (no bypass).
// Backpressure: none on the input; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module window_average_stream #(
    parameter int N          = 4,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    window_average_stream_if.slave  bus
`ifdef PEAK_TRACK_EN
    ,
    output logic [DW-1:0]           out_peak
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [N-1:0]  CNT_MAX  = '1;
    localparam logic [DW:0]   ROUND    = (DW+1)'(2 ** (N - 1));
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    // Elaboration-time guard on the parameter ranges the arithmetic relies on.
    generate
        if (N < 1) begin : g_bad_n
            $error("window_average_stream: N must be >= 1");
        end
        if (DW <= N) begin : g_bad_dw
            $error("window_average_stream: DW must exceed N");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("window_average_stream: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // Warm-up tracking
    logic [N-1:0]    r_cnt;
    logic            r_warm_done;

    // FIFO state
    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [DW-1:0]   r_hold;
    logic            r_overflow;

    // Datapath / control wires
    logic [DW:0]     w_sum_ext;
    logic [DW-1:0]   w_avg;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // Rounding add in DW+1 bits so a full-scale sum cannot wrap before the shift.
    always_comb begin
        w_sum_ext = {1'b0, bus.in_sum} + ROUND;
        w_avg     = DW'(w_sum_ext >> N);
    end

    // Push/pop decisions; pop is judged on the pre-edge level so a fresh entry is never bypassed.
    always_comb begin
        w_empty    = 1'b0;
        w_full     = 1'b0;
        w_push_req = 1'b0;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        w_drop     = 1'b0;

        w_empty    = (r_level == '0);
        w_full     = (r_level == LVL_FULL);
        w_push_req = bus.in_en && r_warm_done;
        w_pop      = !w_empty && bus.out_ready;
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
    end

    // Warm-up counter: counts accepted samples up to 2**N-1 and then stays; warm_done follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_warm_done <= 1'b0;
        end else if (clr) begin
            r_cnt       <= '0;
            r_warm_done <= 1'b0;
        end else if (bus.in_en && !r_warm_done) begin
            r_cnt       <= r_cnt + 1'b1;
            r_warm_done <= (r_cnt == (CNT_MAX - 1'b1));
        end
    end

    // FIFO storage: the rounded average lands at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clr && w_push) begin
            r_mem[r_wr_ptr] <= w_avg;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Last popped value, shown on out_data while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (clr) begin
            r_hold <= '0;
        end else if (w_pop) begin
            r_hold <= r_mem[r_rd_ptr];
        end
    end

    // Sticky drop flag: set when an average is lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef PEAK_TRACK_EN
    logic [DW-1:0] r_peak;

    // Running maximum of every average offered to the FIFO, dropped ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (clr) begin
            r_peak <= '0;
        end else if (w_push_req && (w_avg > r_peak)) begin
            r_peak <= w_avg;
        end
    end

    assign out_peak = r_peak;
`endif

    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign bus.warm_done  = r_warm_done;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_window_average_stream.sv
// Bench for window_average_stream: directed scenarios plus random traffic against a queue model.
// Latency: model is updated per clock edge and compared 1 ns after each rising edge.
// Backpressure: out_ready is driven both directed and with varying random duty to reach full/overflow.
module tb_window_average_stream;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int D    = 4;
    localparam int WIN  = 16;
    localparam int HALF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    window_average_stream_if #(.DW(DW), .FIFO_DEPTH(D)) bus ();

`ifdef PEAK_TRACK_EN
    logic [DW-1:0] out_peak;
`endif

    window_average_stream #(.N(N), .DW(DW), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
`ifdef PEAK_TRACK_EN
        ,
        .out_peak (out_peak)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted-sample count, queue of averages, last popped value, flags.
    int m_cnt;
    int m_q[$];
    int m_last;
    int m_ovf;
    int m_peak;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int avg_of(input int s);
        return (s + HALF) / WIN;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_q.delete();
        m_last = 0;
        m_ovf  = 0;
        m_peak = 0;
    endtask

    task automatic model_edge(input bit c, input bit e, input int s, input bit r);
        bit pop;
        bit push;
        int a;
        if (c) begin
            model_reset();
        end else begin
            pop  = (m_q.size() > 0) && r;
            push = e && (m_cnt == WIN - 1);
            a    = avg_of(s);
            if (e && (m_cnt < WIN - 1)) m_cnt++;
            if (push && (a > m_peak)) m_peak = a;
            if (pop) m_last = m_q.pop_front();
            if (push) begin
                if (m_q.size() < D) m_q.push_back(a);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all(input string where);
        int ev;
        int ed;
        ev = (m_q.size() > 0) ? 1 : 0;
        ed = (m_q.size() > 0) ? m_q[0] : m_last;
        chk({where, ".level"}, 32'(bus.fifo_level), 32'(m_q.size()));
        chk({where, ".valid"}, 32'(bus.out_valid),  32'(ev));
        chk({where, ".data"},  32'(bus.out_data),   32'(ed));
        chk({where, ".warm"},  32'(bus.warm_done),  32'((m_cnt == WIN - 1) ? 1 : 0));
        chk({where, ".ovf"},   32'(bus.overflow),   32'(m_ovf));
`ifdef PEAK_TRACK_EN
        chk({where, ".peak"},  32'(out_peak),       32'(m_peak));
`endif
    endtask

    // One clock: drive inputs away from the edge, advance the model, compare just after the edge.
    task automatic step(input bit c, input bit e, input int s, input bit r);
        clr           = c;
        bus.in_en     = e;
        bus.in_sum    = DW'(s);
        bus.out_ready = r;
        @(posedge clk);
        model_edge(c, e, s, r);
        #1;
        compare_all("step");
    endtask

    task automatic warm_up();
        repeat (WIN - 1) step(1'b0, 1'b1, int'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic async_reset_pulse();
        clr           = 1'b0;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("arst");
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int v[4];
        int ev[4];
        bit c;
        bit e;
        bit r;
        int s;
        int duty;

        bus.in_en     = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset state
        #7;
        compare_all("reset");
        chk("reset.data0", 32'(bus.out_data), 32'd0);
        rst_n = 1'b1;

        // Warm-up discards the first 15 samples, 16th is queued
        for (int i = 1; i <= WIN - 1; i++) begin
            step(1'b0, 1'b1, 100, 1'b0);
            chk("tp1.level", 32'(bus.fifo_level), 32'd0);
            chk("tp1.warm",  32'(bus.warm_done),  (i == WIN - 1) ? 32'd1 : 32'd0);
        end
        step(1'b0, 1'b1, 100, 1'b0);
        chk("tp1.data",  32'(bus.out_data),  32'd6);
        chk("tp1.valid", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Rounding sequence streamed with ready high
        v  = '{7, 8, 24, 255};
        ev = '{0, 1, 2, 16};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, v[i], 1'b1);
            chk("tp2.data", 32'(bus.out_data), 32'(ev[i]));
        end
        step(1'b0, 1'b0, 0, 1'b1);
        chk("tp2.ovf",   32'(bus.overflow),  32'd0);
        chk("tp2.valid", 32'(bus.out_valid), 32'd0);

        // Fill past full with ready low, then drain
        repeat (5) step(1'b0, 1'b1, 160, 1'b0);
        chk("tp3.level", 32'(bus.fifo_level), 32'd4);
        chk("tp3.ovf",   32'(bus.overflow),   32'd1);
        chk("tp3.head",  32'(bus.out_data),   32'd10);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            if (i < 3) chk("tp3.drain", 32'(bus.out_data), 32'd10);
        end
        chk("tp3.valid", 32'(bus.out_valid), 32'd0);

        // Full with simultaneous push and pop
        step(1'b1, 1'b0, 0, 1'b0);
        warm_up();
        repeat (4) step(1'b0, 1'b1, 160, 1'b0);
        step(1'b0, 1'b1, 32, 1'b1);
        chk("tp4.level", 32'(bus.fifo_level), 32'd4);
        chk("tp4.ovf",   32'(bus.overflow),   32'd0);
        repeat (4) step(1'b0, 1'b0, 0, 1'b1);
        chk("tp4.tail",  32'(bus.out_data),   32'd2);

        // clr mid-stream with 3 entries queued
        repeat (3) step(1'b0, 1'b1, 80, 1'b0);
        chk("tp5.level3", 32'(bus.fifo_level), 32'd3);
        step(1'b1, 1'b1, 80, 1'b1);
        chk("tp5.clr_level", 32'(bus.fifo_level), 32'd0);
        chk("tp5.clr_warm",  32'(bus.warm_done),  32'd0);
        chk("tp5.clr_ovf",   32'(bus.overflow),   32'd0);
        repeat (WIN - 1) begin
            step(1'b0, 1'b1, 80, 1'b0);
            chk("tp5.discard", 32'(bus.fifo_level), 32'd0);
        end
        repeat (3) step(1'b0, 1'b1, 80, 1'b0);
        chk("tp5.requeue", 32'(bus.fifo_level), 32'd3);

        // Same with an asynchronous reset pulse between edges
        async_reset_pulse();
        chk("tp5.arst_level", 32'(bus.fifo_level), 32'd0);
        chk("tp5.arst_warm",  32'(bus.warm_done),  32'd0);
        repeat (WIN - 1) begin
            step(1'b0, 1'b1, 80, 1'b0);
            chk("tp5.arst_discard", 32'(bus.fifo_level), 32'd0);
        end

`ifdef PEAK_TRACK_EN
        // Peak tracking: averages 3, 9, 5 then clear
        step(1'b1, 1'b0, 0, 1'b0);
        warm_up();
        step(1'b0, 1'b1, 48, 1'b1);
        chk("peak.a", 32'(out_peak), 32'd3);
        step(1'b0, 1'b1, 144, 1'b1);
        chk("peak.b", 32'(out_peak), 32'd9);
        step(1'b0, 1'b1, 80, 1'b1);
        chk("peak.c", 32'(out_peak), 32'd9);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("peak.clr", 32'(out_peak), 32'd0);
`endif

        // Random traffic with alternating consumer duty cycle
        for (int i = 0; i < 800; i++) begin
            duty = ((i / 100) % 2 == 1) ? 2 : 8;
            c    = ($urandom_range(0, 79) == 0);
            e    = ($urandom_range(0, 9) < 7);
            s    = int'($urandom_range(0, 255));
            r    = ($urandom_range(0, 9) < duty);
            step(c, e, s, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
